team_06_leveler: RTL and testbench



---
 rtl/team_06_audio_pkg.sv | 44 ++++
 rtl/team_06_envelope_tracker.sv | 117 +++++++++++
 rtl/team_06_leveler.sv | 78 +++++++
 tb/tb_team_06_leveler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/team_06_audio_pkg.sv
// Shared types, tuning constants and arithmetic helpers for the team_06 audio level controller.
package team_06_audio_pkg;

    typedef logic [7:0] sample_t;
    typedef logic [7:0] gain_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } lvl_state_t;

    localparam gain_t       GAIN_UNITY   = 8'd16;
    localparam sample_t     TARGET       = 8'd192;
    localparam sample_t     TOL          = 8'd8;
    localparam sample_t     LEVEL_HI     = TARGET + TOL;
    localparam sample_t     LEVEL_LO     = TARGET - TOL;
    localparam gain_t       GAIN_MIN     = 8'd4;
    localparam gain_t       GAIN_MAX     = 8'd64;
    localparam sample_t     NOISE_FLOOR  = 8'd16;
    localparam int unsigned ATTACK_SHIFT = 32'd2;
    localparam logic [5:0]  HOLD_SAMPLES = 6'd32;
    localparam int unsigned RELEASE_DIV  = 32'd64;
    localparam logic [5:0]  REL_LAST     = 6'(RELEASE_DIV - 32'd1);

    function automatic sample_t sat255(input logic [15:0] value);
        sample_t result;
        if (value > 16'd255) begin
            result = 8'd255;
        end else begin
            result = value[7:0];
        end
        return result;
    endfunction

    // Unsigned sample times Q4.4 gain, back to integer scale, clipped to 8 bits.
    function automatic sample_t scale_q44(input sample_t sample, input gain_t g);
        logic [15:0] prod;
        prod = 16'(sample) * 16'(g);
        return sat255(prod >> 4);
    endfunction

endpackage

// File: rtl/team_06_envelope_tracker.sv
// Peak envelope follower: fast proportional attack, fixed hold after the last rise,
// then a slow 1-LSB-per-RELEASE_DIV-strobes decay.
module team_06_envelope_tracker
    import team_06_audio_pkg::*;
(
    input  logic       clkdiv,
    input  logic       rst,
    input  logic       en,
    input  logic       sample_strobe,
    input  logic [7:0] audio_in,
    output logic [7:0] env
);

    lvl_state_t state_r;
    lvl_state_t state_nxt_s;
    sample_t    env_r;
    sample_t    env_nxt_s;
    sample_t    diff_s;
    sample_t    step_s;
    logic [5:0] hold_cnt_r;
    logic [5:0] hold_cnt_nxt_s;
    logic [5:0] rel_cnt_r;
    logic [5:0] rel_cnt_nxt_s;
    logic       rise_s;
    logic       hold_ok_s;

    // Attack step size and hold eligibility from the current state.
    always_comb begin
        rise_s = (audio_in > env_r);
        diff_s = audio_in - env_r;
        if ((diff_s >> ATTACK_SHIFT) == 8'd0) begin
            step_s = 8'd1;
        end else begin
            step_s = diff_s >> ATTACK_SHIFT;
        end
        case (state_r)
            ATTACK, HOLD: hold_ok_s = (hold_cnt_r != 6'd0);
            default:      hold_ok_s = 1'b0;
        endcase
    end

    // Next-state selection; only an enabled strobe moves the FSM, disable forces IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (!en) begin
            state_nxt_s = IDLE;
        end else if (sample_strobe) begin
            if (rise_s) begin
                state_nxt_s = ATTACK;
            end else if (hold_ok_s) begin
                state_nxt_s = HOLD;
            end else begin
                state_nxt_s = RELEASE;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Envelope and counter updates implied by the chosen transition.
    always_comb begin
        env_nxt_s      = env_r;
        hold_cnt_nxt_s = hold_cnt_r;
        rel_cnt_nxt_s  = rel_cnt_r;
        if (!en) begin
            env_nxt_s      = 8'd0;
            hold_cnt_nxt_s = 6'd0;
            rel_cnt_nxt_s  = 6'd0;
        end else if (sample_strobe) begin
            case (state_nxt_s)
                ATTACK: begin
                    env_nxt_s      = env_r + step_s;
                    hold_cnt_nxt_s = HOLD_SAMPLES;
                    rel_cnt_nxt_s  = 6'd0;
                end
                HOLD: begin
                    hold_cnt_nxt_s = hold_cnt_r - 6'd1;
                end
                RELEASE: begin
                    if (rel_cnt_r == REL_LAST) begin
                        rel_cnt_nxt_s = 6'd0;
                        if (env_r != 8'd0) begin
                            env_nxt_s = env_r - 8'd1;
                        end else begin
                            env_nxt_s = env_r;
                        end
                    end else begin
                        rel_cnt_nxt_s = rel_cnt_r + 6'd1;
                    end
                end
                default: begin
                    env_nxt_s = env_r;
                end
            endcase
        end else begin
            env_nxt_s = env_r;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            env_r      <= 8'd0;
            hold_cnt_r <= 6'd0;
            rel_cnt_r  <= 6'd0;
        end else begin
            state_r    <= state_nxt_s;
            env_r      <= env_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            rel_cnt_r  <= rel_cnt_nxt_s;
        end
    end

    assign env = env_r;

endmodule

// File: rtl/team_06_leveler.sv
// Automatic level control: envelope tracker drives a +/-1 per strobe Q4.4 gain servo,
// and the gain scales each accepted sample into a registered output.
module team_06_leveler
    import team_06_audio_pkg::*;
(
    input  logic       clkdiv,
    input  logic       rst,
    input  logic       en,
    input  logic       sample_strobe,
    input  logic [7:0] audio_in,
    output logic [7:0] audio_out,
    output logic       out_valid,
    output logic [7:0] gain
);

    sample_t env_s;
    sample_t level_s;
    sample_t scaled_s;
    sample_t audio_out_r;
    logic    out_valid_r;
    gain_t   gain_r;
    gain_t   gain_nxt_s;

    team_06_envelope_tracker u_env_tracker (
        .clkdiv        (clkdiv),
        .rst           (rst),
        .en            (en),
        .sample_strobe (sample_strobe),
        .audio_in      (audio_in),
        .env           (env_s)
    );

    // Level estimate and output sample both use the gain in force before this strobe.
    always_comb begin
        level_s  = scale_q44(env_s, gain_r);
        scaled_s = scale_q44(audio_in, gain_r);
    end

    // Gain servo; no boost below the noise floor so silence is not amplified.
    always_comb begin
        gain_nxt_s = gain_r;
        if (!en) begin
            gain_nxt_s = GAIN_UNITY;
        end else if (sample_strobe) begin
            if ((level_s > LEVEL_HI) && (gain_r > GAIN_MIN)) begin
                gain_nxt_s = gain_r - 8'd1;
            end else if ((level_s < LEVEL_LO) && (gain_r < GAIN_MAX) && (env_s >= NOISE_FLOOR)) begin
                gain_nxt_s = gain_r + 8'd1;
            end else begin
                gain_nxt_s = gain_r;
            end
        end else begin
            gain_nxt_s = gain_r;
        end
    end

    // Output and gain registers.
    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            audio_out_r <= 8'd0;
            out_valid_r <= 1'b0;
            gain_r      <= GAIN_UNITY;
        end else begin
            out_valid_r <= sample_strobe;
            gain_r      <= gain_nxt_s;
            if (sample_strobe) begin
                audio_out_r <= en ? scaled_s : audio_in;
            end else begin
                audio_out_r <= audio_out_r;
            end
        end
    end

    assign audio_out = audio_out_r;
    assign out_valid = out_valid_r;
    assign gain      = gain_r;

endmodule

// File: tb/tb_team_06_leveler.sv
// Randomized and directed bench for team_06_leveler against a plain-arithmetic level-control model.
module tb_team_06_leveler;

    logic       clkdiv = 1'b0;
    logic       rst;
    logic       en;
    logic       sample_strobe;
    logic [7:0] audio_in;
    logic [7:0] audio_out;
    logic       out_valid;
    logic [7:0] gain;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int  m_env, m_gain, m_hold, m_rel, m_out;
    bit  m_valid, m_busy;

    team_06_leveler dut (
        .clkdiv        (clkdiv),
        .rst           (rst),
        .en            (en),
        .sample_strobe (sample_strobe),
        .audio_in      (audio_in),
        .audio_out     (audio_out),
        .out_valid     (out_valid),
        .gain          (gain)
    );

    always #5 clkdiv = ~clkdiv;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic m_reset();
        m_env = 0; m_gain = 16; m_hold = 0; m_rel = 0; m_out = 0; m_valid = 0; m_busy = 0;
    endtask

    task automatic m_step(input bit e, input bit s, input int x);
        int lvl, ng, st;
        m_valid = s;
        if (!e) begin
            if (s) m_out = x;
            m_env = 0; m_gain = 16; m_hold = 0; m_rel = 0; m_busy = 0;
            return;
        end
        if (!s) return;
        m_out = sat((x * m_gain) / 16);
        lvl = sat((m_env * m_gain) / 16);
        ng = m_gain;
        if (lvl > 200 && m_gain > 4) ng = m_gain - 1;
        else if (lvl < 184 && m_gain < 64 && m_env >= 16) ng = m_gain + 1;
        if (x > m_env) begin
            st = (x - m_env) / 4;
            if (st < 1) st = 1;
            m_env = m_env + st;
            m_hold = 32; m_rel = 0; m_busy = 1;
        end else if (m_busy && m_hold > 0) begin
            m_hold = m_hold - 1;
        end else begin
            m_busy = 0;
            m_rel = m_rel + 1;
            if (m_rel == 64) begin
                m_rel = 0;
                if (m_env > 0) m_env = m_env - 1;
            end
        end
        m_gain = ng;
    endtask

    task automatic cyc(input bit e, input bit s, input int x, input string tag);
        @(negedge clkdiv);
        en = e; sample_strobe = s; audio_in = x[7:0];
        @(posedge clkdiv);
        #1;
        m_step(e, s, x);
        check_val({tag, ".audio_out"}, 16'(audio_out), 16'(m_out));
        check_val({tag, ".out_valid"}, 16'(out_valid), 16'(m_valid));
        check_val({tag, ".gain"}, 16'(gain), 16'(m_gain));
        check_val({tag, ".env"}, 16'(dut.env_s), 16'(m_env));
    endtask

    int att_env[4] = '{50, 87, 115, 136};

    initial begin
        int base, x;
        rst = 1'b1; en = 1'b0; sample_strobe = 1'b0; audio_in = 8'd0;
        m_reset();
        repeat (2) @(negedge clkdiv);
        rst = 1'b0;

        // Build some state, then reset asynchronously mid-cycle
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 200, "pre");
        @(posedge clkdiv);
        #3 rst = 1'b1;
        #1;
        check_val("rst.audio_out", 16'(audio_out), 16'd0);
        check_val("rst.out_valid", 16'(out_valid), 16'd0);
        check_val("rst.gain", 16'(gain), 16'd16);
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clkdiv);
            en = 1'b1; sample_strobe = 1'b1; audio_in = 8'd99;
            @(posedge clkdiv);
            #1;
            check_val("rst.strobe_valid", 16'(out_valid), 16'd0);
            check_val("rst.strobe_out", 16'(audio_out), 16'd0);
        end
        @(negedge clkdiv);
        sample_strobe = 1'b0; rst = 1'b0;

        // Bypass
        cyc(1'b0, 1'b1, 200, "bypass");
        check_val("bypass.out", 16'(audio_out), 16'd200);
        check_val("bypass.valid", 16'(out_valid), 16'd1);
        check_val("bypass.gain", 16'(gain), 16'd16);
        cyc(1'b0, 1'b0, 0, "bypass_idle");
        check_val("bypass.valid_drop", 16'(out_valid), 16'd0);

        // Attack from env=0
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 200, "attack");
            check_val("attack.env", 16'(dut.env_s), 16'(att_env[i]));
            if (i == 0) check_val("attack.first_out", 16'(audio_out), 16'd200);
        end

        // Boost: quiet constant input
        cyc(1'b0, 1'b0, 0, "clear");
        for (int i = 0; i < 80; i++) cyc(1'b1, 1'b1, 64, "boost");
        check_val("boost.gain", 16'(gain), 16'd46);
        check_val("boost.out", 16'(audio_out), 16'd184);

        // Cut: full-scale constant input
        for (int i = 0; i < 90; i++) cyc(1'b1, 1'b1, 255, "cut");
        check_val("cut.gain", 16'(gain), 16'd12);
        check_val("cut.out", 16'(audio_out), 16'd191);

        // Release on silence, then abort by disabling mid-release
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 0, "release");
        cyc(1'b1, 1'b0, 0, "release_gap");
        cyc(1'b0, 1'b0, 0, "abort");
        check_val("abort.env", 16'(dut.env_s), 16'd0);
        check_val("abort.gain", 16'(gain), 16'd16);

        // Drive gain to its ceiling, then a full-scale sample must saturate
        for (int i = 0; i < 80; i++) cyc(1'b1, 1'b1, 16, "ceiling");
        check_val("ceiling.gain", 16'(gain), 16'd64);
        cyc(1'b1, 1'b1, 255, "sat");
        check_val("sat.out", 16'(audio_out), 16'd255);

        // Randomized: per block a base level with jitter, random strobes/enables, sync reset pulses
        for (int blk = 0; blk < 20; blk++) begin
            base = $urandom_range(0, 255);
            for (int i = 0; i < 120; i++) begin
                x = base + $urandom_range(0, 40) - 20;
                if (x < 0) x = 0;
                if (x > 255) x = 255;
                cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), x, "rand");
            end
            if ((blk % 5) == 4) begin
                @(negedge clkdiv);
                rst = 1'b1; sample_strobe = 1'b1;
                @(posedge clkdiv);
                #1;
                m_reset();
                check_val("rand.rst_valid", 16'(out_valid), 16'd0);
                check_val("rand.rst_gain", 16'(gain), 16'd16);
                @(negedge clkdiv);
                rst = 1'b0; sample_strobe = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
